alert_scheduler: RTL and testbench
==================================

// Module: alert_scheduler
// PURPOSE
//  Arbitrates the single alert LED between three requesters: N programmable alarm slots,
//  countdown-timer expiry and (optional) hourly chime. Holds the alarm table, detects matches
//  against time-of-day, sequences alert/snooze, drives the blink pattern. Runs on the 1 Hz tick
//  beside the time-of-day counter; replaces the single-slot alarm compare/blink logic.
// PARAMETERS
//  N_ALARMS     4    alarm slots; index width IW = $clog2(N_ALARMS)
//  ALERT_SECS   10   alert duration in clk_1Hz cycles (alarm, timer)
//  SNOOZE_SECS  300  snooze delay before an alarm re-fires
//  CHIME_SECS   2    chime duration (HOURLY_CHIME_EN only)
// PORTS
//  clk_1Hz       in   1   1 Hz tick clock
//  reset         in   1   asynchronous, active-high
//  cur_hrs       in   5   time-of-day hours 0..23
//  cur_mins      in   6   time-of-day minutes 0..59
//  cur_secs      in   6   time-of-day seconds 0..59
//  alm_wr_en     in   1   write alarm slot this cycle
//  alm_wr_idx    in   IW  slot to write
//  alm_wr_hrs    in   5   slot hours
//  alm_wr_mins   in   6   slot minutes
//  alm_wr_arm    in   1   slot armed flag
//  timer_done    in   1   countdown reached 00:00 (one-cycle pulse)
//  ack           in   1   user acknowledge (debounced, >=1 cycle)
//  snooze        in   1   user snooze (debounced, >=1 cycle)
//  led           out  1   alert LED
//  alert_active  out  1   FSM in ALERT
//  alert_src     out  2   0 none, 1 alarm, 2 timer, 3 chime
//  snooze_pend   out  1   snooze countdown running
// BEHAVIOUR
//  - Reset: all outputs 0; table cleared (all slots disarmed, 00:00); pending bits, counters 0; FSM IDLE.
//  - Alarm request: any armed slot with hrs/mins == cur and cur_secs==0; lowest index wins.
//    Snooze counter reaching 0 also raises alarm request. Timer request = timer_done.
//  - Requests latch into pending[src]; a source already pending or being served coalesces (dropped).
//  - FSM IDLE: pick pending by priority alarm > timer > chime; clear its bit; load dur counter;
//    -> ALERT on same edge. Outputs registered: 1-cycle latency from request to led/alert_active.
//  - ALERT: alarm/timer: led=1 first cycle then toggles each cycle; chime: led solid 1.
//    Exit to IDLE when dur counter expires, or ack=1 (next edge). Exit always passes through IDLE
//    for exactly 1 cycle (led=0) before serving the next pending request.
//  - snooze=1 in ALERT with src=alarm: -> IDLE, load snooze counter SNOOZE_SECS, snooze_pend=1.
//    snooze ignored for other sources. ack during or after alarm alert clears snooze_pend/counter.
//    Snooze while already pending reloads counter.
//  - Simultaneous ack+snooze: ack wins. Table write same cycle as match: match uses old contents;
//    write visible next cycle. Write of slot being served does not stop current alert.
//  - Reset mid-ALERT/SNOOZE: immediate return to reset state, nothing retained.
//  - Counters sized $clog2(max(param)+1); no wrap: saturate at 0.
// CONFIGURATION
//  HOURLY_CHIME_EN defined: chime request when cur_mins==0 && cur_secs==0; lowest priority, CHIME_SECS.
//  Undefined: no chime logic; alert_src never 3; pending[chime] tied 0.
// STRUCTURE
//  Package clock_pkg: HRS_W=5, MIN_W=6, SEC_W=6; enum state_t {IDLE, ALERT}; enum src_t
//  {SRC_NONE, SRC_ALARM, SRC_TIMER, SRC_CHIME}. Sub-module alarm_table: slot storage, write port,
//  parallel compare, priority encoder -> match pulse + index.
// TESTING
//  1 Assert reset mid-run -> led=0, alert_active=0, alert_src=0, snooze_pend=0; all slots disarmed.
//  2 Slot 2 = 07:30 armed; drive 07:30:00 -> next cycle src=1, led 1,0,1,0.. 10 cycles, then IDLE.
//  3 As 2, ack on alert cycle 3 -> next cycle alert_active=0, led=0; no re-fire at 07:30:01.
//  4 As 2, snooze on cycle 2 -> IDLE, snooze_pend=1; 300 cycles later alarm alert again; ack clears.
//  5 timer_done with alarm match same cycle -> alarm 10 cycles, 1 idle cycle, timer 10 cycles.
//  6 HOURLY_CHIME_EN: 13:00:00 -> src=3, led solid 2 cycles; without macro -> no alert.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared time-field widths, FSM state and alert source encodings
package clock_pkg;
    localparam int HRS_W = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;
    typedef enum logic {IDLE, ALERT} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_ALARM, SRC_TIMER, SRC_CHIME} src_t;
endpackage

// File: rtl/alarm_table.sv
// alarm_table: alarm slot storage, write port, parallel time compare, lowest-index priority match
module alarm_table import clock_pkg::*; #(
    parameter int N_ALARMS = 4,
    parameter int IW = $clog2(N_ALARMS)
) (
    input  logic             clk_1Hz,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [HRS_W-1:0] wr_hrs,
    input  logic [MIN_W-1:0] wr_mins,
    input  logic             wr_arm,
    input  logic [HRS_W-1:0] cur_hrs,
    input  logic [MIN_W-1:0] cur_mins,
    input  logic [SEC_W-1:0] cur_secs,
    output logic             match
);
    logic [HRS_W-1:0]    hrs_q  [N_ALARMS];
    logic [HRS_W-1:0]    hrs_d  [N_ALARMS];
    logic [MIN_W-1:0]    mins_q [N_ALARMS];
    logic [MIN_W-1:0]    mins_d [N_ALARMS];
    logic [N_ALARMS-1:0] arm_q, arm_d, hit;
    logic [IW-1:0]       idx;

    // only the addressed slot changes; the compare below still sees the old contents this cycle
    always_comb begin
        hrs_d  = hrs_q;
        mins_d = mins_q;
        arm_d  = arm_q;
        if (wr_en) begin
            hrs_d[wr_idx]  = wr_hrs;
            mins_d[wr_idx] = wr_mins;
            arm_d[wr_idx]  = wr_arm;
        end
    end

    // compare all armed slots at the top of the minute and pick the lowest-index hit
    always_comb begin
        hit = '0;
        idx = '0;
        for (int i = 0; i < N_ALARMS; i++)
            hit[i] = arm_q[i] && hrs_q[i] == cur_hrs && mins_q[i] == cur_mins && cur_secs == '0;
        for (int i = N_ALARMS - 1; i >= 0; i--)
            if (hit[i]) idx = IW'(i);
        match = hit[idx];
    end

    // slot registers; reset leaves every slot disarmed at 00:00
    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            hrs_q  <= '{default: '0};
            mins_q <= '{default: '0};
            arm_q  <= '0;
        end else begin
            hrs_q  <= hrs_d;
            mins_q <= mins_d;
            arm_q  <= arm_d;
        end
    end
endmodule

// File: rtl/alert_scheduler.sv
// alert_scheduler: arbitrates the alert LED between alarm slots, timer expiry and hourly chime (HOURLY_CHIME_EN)
module alert_scheduler import clock_pkg::*; #(
    parameter int N_ALARMS    = 4,
    parameter int ALERT_SECS  = 10,
    parameter int SNOOZE_SECS = 300,
    parameter int CHIME_SECS  = 2,
    parameter int IW          = $clog2(N_ALARMS)
) (
    input  logic             clk_1Hz,
    input  logic             reset,
    input  logic [HRS_W-1:0] cur_hrs,
    input  logic [MIN_W-1:0] cur_mins,
    input  logic [SEC_W-1:0] cur_secs,
    input  logic             alm_wr_en,
    input  logic [IW-1:0]    alm_wr_idx,
    input  logic [HRS_W-1:0] alm_wr_hrs,
    input  logic [MIN_W-1:0] alm_wr_mins,
    input  logic             alm_wr_arm,
    input  logic             timer_done,
    input  logic             ack,
    input  logic             snooze,
    output logic             led,
    output logic             alert_active,
    output logic [1:0]       alert_src,
    output logic             snooze_pend
);
    localparam int DUR_MAX = ALERT_SECS > CHIME_SECS ? ALERT_SECS : CHIME_SECS;
    localparam int DW = $clog2(DUR_MAX + 1);
    localparam int SW = $clog2(SNOOZE_SECS + 1);

    state_t        state_q, state_d;
    src_t          src_q, src_d;
    logic          led_q, led_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [3:1]    pend_q, pend_d, req, busy;
    logic          snz_pend_q, snz_pend_d, snz_fire;
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic          alm_match, chime_req;

    alarm_table #(.N_ALARMS(N_ALARMS), .IW(IW)) u_table (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .wr_en   (alm_wr_en),
        .wr_idx  (alm_wr_idx),
        .wr_hrs  (alm_wr_hrs),
        .wr_mins (alm_wr_mins),
        .wr_arm  (alm_wr_arm),
        .cur_hrs (cur_hrs),
        .cur_mins(cur_mins),
        .cur_secs(cur_secs),
        .match   (alm_match)
    );

`ifdef HOURLY_CHIME_EN
    assign chime_req = cur_mins == '0 && cur_secs == '0;
`else
    assign chime_req = 1'b0;
`endif

    assign snz_fire = snz_pend_q && snz_cnt_q == SW'(1);
    assign req      = {chime_req, timer_done, alm_match || snz_fire};
    assign busy     = state_q == ALERT ? {src_q == SRC_CHIME, src_q == SRC_TIMER, src_q == SRC_ALARM} : 3'b000;

    // latch requests, serve the best pending one from IDLE, sequence alert exit and snooze
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        led_d      = led_q;
        dur_d      = dur_q;
        pend_d     = pend_q | (req & ~busy);
        snz_pend_d = snz_pend_q && !snz_fire;
        snz_cnt_d  = snz_cnt_q == '0 ? '0 : snz_cnt_q - SW'(1);
        if (state_q == IDLE) begin
            if (|pend_d) begin
                state_d = ALERT;
                led_d   = 1'b1;
                src_d   = pend_d[1] ? SRC_ALARM : pend_d[2] ? SRC_TIMER : SRC_CHIME;
                dur_d   = (pend_d[1] || pend_d[2]) ? DW'(ALERT_SECS - 1) : DW'(CHIME_SECS - 1);
                pend_d  = pend_d & ~(pend_d[1] ? 3'b001 : pend_d[2] ? 3'b010 : 3'b100);
            end
        end else if (ack || dur_q == '0 || (snooze && src_q == SRC_ALARM)) begin
            state_d = IDLE;
            src_d   = SRC_NONE;
            led_d   = 1'b0;
            dur_d   = '0;
            if (!ack && snooze && src_q == SRC_ALARM) begin
                snz_pend_d = 1'b1;
                snz_cnt_d  = SW'(SNOOZE_SECS);
            end
        end else begin
            dur_d = dur_q - DW'(1);
            led_d = src_q == SRC_CHIME || !led_q;
        end
        if (ack && (state_q == IDLE || src_q == SRC_ALARM)) begin
            snz_pend_d = 1'b0;
            snz_cnt_d  = '0;
        end
    end

    // all scheduler state and registered outputs; reset drops everything immediately
    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            src_q      <= SRC_NONE;
            led_q      <= 1'b0;
            dur_q      <= '0;
            pend_q     <= '0;
            snz_pend_q <= 1'b0;
            snz_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            led_q      <= led_d;
            dur_q      <= dur_d;
            pend_q     <= pend_d;
            snz_pend_q <= snz_pend_d;
            snz_cnt_q  <= snz_cnt_d;
        end
    end

    assign led          = led_q;
    assign alert_active = state_q == ALERT;
    assign alert_src    = src_q;
    assign snooze_pend  = snz_pend_q;
endmodule

// File: tb/tb_alert_scheduler.sv
// tb_alert_scheduler: directed stimulus, timeline-based reference model and literal spot checks
module tb_alert_scheduler;
    logic       clk_1Hz = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] cur_hrs;
    logic [5:0] cur_mins, cur_secs;
    logic       alm_wr_en, alm_wr_arm, timer_done, ack, snooze;
    logic [1:0] alm_wr_idx;
    logic [4:0] alm_wr_hrs;
    logic [5:0] alm_wr_mins;
    logic       led, alert_active, snooze_pend;
    logic [1:0] alert_src;

    int checks = 0;
    int errors = 0;

    alert_scheduler dut (
        .clk_1Hz     (clk_1Hz),
        .reset       (reset),
        .cur_hrs     (cur_hrs),
        .cur_mins    (cur_mins),
        .cur_secs    (cur_secs),
        .alm_wr_en   (alm_wr_en),
        .alm_wr_idx  (alm_wr_idx),
        .alm_wr_hrs  (alm_wr_hrs),
        .alm_wr_mins (alm_wr_mins),
        .alm_wr_arm  (alm_wr_arm),
        .timer_done  (timer_done),
        .ack         (ack),
        .snooze      (snooze),
        .led         (led),
        .alert_active(alert_active),
        .alert_src   (alert_src),
        .snooze_pend (snooze_pend)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an alert is a time window [m_start, m_start+m_len) in tick numbers,
    // pending requests are a set, snooze is an absolute deadline tick.
    int n = 0;
    int m_start, m_len, m_src, snz_dl;
    bit m_act, snz_on, a_hit, s_hit;
    bit [3:1] p, r;
    int t_h[4], t_m[4];
    bit t_a[4];

    always @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            m_act = 0; m_src = 0; p = '0; snz_on = 0;
            for (int i = 0; i < 4; i++) begin t_h[i] = 0; t_m[i] = 0; t_a[i] = 0; end
        end else begin
            n++;
            a_hit = 0;
            for (int i = 0; i < 4; i++)
                if (t_a[i] && t_h[i] == cur_hrs && t_m[i] == cur_mins && cur_secs == 0) a_hit = 1;
            s_hit = snz_on && n == snz_dl;
            if (s_hit) snz_on = 0;
            r[1] = a_hit || s_hit;
            r[2] = timer_done;
`ifdef HOURLY_CHIME_EN
            r[3] = cur_mins == 0 && cur_secs == 0;
`else
            r[3] = 0;
`endif
            for (int s = 1; s <= 3; s++)
                if (r[s] && !(m_act && m_src == s)) p[s] = 1;
            if (ack && (!m_act || m_src == 1)) snz_on = 0;
            if (m_act) begin
                if (ack || n - m_start >= m_len || (snooze && m_src == 1)) begin
                    if (snooze && !ack && m_src == 1) begin snz_on = 1; snz_dl = n + 300; end
                    m_act = 0;
                    m_src = 0;
                end
            end else if (p != 0) begin
                m_src = p[1] ? 1 : p[2] ? 2 : 3;
                p[m_src] = 0;
                m_act = 1;
                m_start = n;
                m_len = m_src == 3 ? 2 : 10;
            end
            if (alm_wr_en) begin
                t_h[alm_wr_idx] = alm_wr_hrs;
                t_m[alm_wr_idx] = alm_wr_mins;
                t_a[alm_wr_idx] = alm_wr_arm;
            end
        end
    end

    // every falling edge: DUT outputs against the model
    always @(negedge clk_1Hz) begin
        chk("led", led, int'(m_act && (m_src == 3 || (n - m_start) % 2 == 0)));
        chk("alert_active", alert_active, int'(m_act));
        chk("alert_src", alert_src, m_src);
        chk("snooze_pend", snooze_pend, int'(snz_on));
    end

    task automatic cyc();
        @(negedge clk_1Hz);
        #1;
    endtask

    task automatic set_t(input int h, input int m, input int s);
        cur_hrs = 5'(h); cur_mins = 6'(m); cur_secs = 6'(s);
    endtask

    task automatic wr(input int idx, input int h, input int m, input bit arm);
        alm_wr_en = 1; alm_wr_idx = 2'(idx); alm_wr_hrs = 5'(h); alm_wr_mins = 6'(m); alm_wr_arm = arm;
        cyc();
        alm_wr_en = 0;
    endtask

    initial begin
        set_t(1, 2, 3);
        alm_wr_en = 0; alm_wr_idx = 0; alm_wr_hrs = 0; alm_wr_mins = 0; alm_wr_arm = 0;
        timer_done = 0; ack = 0; snooze = 0;
        repeat (2) cyc();
        chk("rst_led", led, 0); chk("rst_active", alert_active, 0);
        chk("rst_src", alert_src, 0); chk("rst_snz", snooze_pend, 0);
        reset = 0;
        cyc();

        // alarm slot 2 at 07:30 runs its full 10-cycle blink
        wr(2, 7, 30, 1);
        set_t(7, 30, 0); cyc(); cur_secs = 1;
        chk("t2_src", alert_src, 1); chk("t2_led1", led, 1);
        for (int k = 2; k <= 10; k++) begin
            cyc();
            chk("t2_blink", led, k % 2);
            chk("t2_act", alert_active, 1);
        end
        cyc();
        chk("t2_end", alert_active, 0); chk("t2_end_led", led, 0);

        // ack on alert cycle 3
        cur_secs = 0; cyc(); cur_secs = 1; cyc(); cyc();
        ack = 1; cyc(); ack = 0;
        chk("t3_ack_act", alert_active, 0); chk("t3_ack_led", led, 0);
        repeat (3) cyc();
        chk("t3_norefire", alert_active, 0);

        // snooze on alert cycle 2, re-fire 300 cycles later
        cur_secs = 0; cyc(); cur_secs = 1; cyc();
        snooze = 1; cyc(); snooze = 0;
        chk("t4_snz_act", alert_active, 0); chk("t4_snz_pend", snooze_pend, 1);
        repeat (299) cyc();
        chk("t4_wait_pend", snooze_pend, 1); chk("t4_wait_act", alert_active, 0);
        cyc();
        chk("t4_refire", alert_active, 1); chk("t4_refire_src", alert_src, 1);
        ack = 1; cyc(); ack = 0;
        chk("t4_ack", alert_active, 0);

        // ack while snooze is pending cancels the re-fire
        cur_secs = 0; cyc(); cur_secs = 1;
        snooze = 1; cyc(); snooze = 0;
        chk("t4c_pend", snooze_pend, 1);
        ack = 1; cyc(); ack = 0;
        chk("t4c_cleared", snooze_pend, 0);
        repeat (305) cyc();
        chk("t4c_none", alert_active, 0);

        // timer and alarm together: alarm, one idle cycle, then timer
        cur_secs = 0; timer_done = 1; cyc(); cur_secs = 1; timer_done = 0;
        chk("t5_first", alert_src, 1);
        repeat (9) cyc();
        chk("t5_alarm_last", alert_src, 1);
        cyc();
        chk("t5_gap", alert_active, 0); chk("t5_gap_led", led, 0);
        cyc();
        chk("t5_timer", alert_src, 2); chk("t5_timer_led", led, 1);
        repeat (9) cyc();
        chk("t5_timer_last", alert_active, 1);
        cyc();
        chk("t5_done", alert_active, 0);

        // disarming write on the match cycle still fires; next match does not
        set_t(7, 30, 0);
        alm_wr_en = 1; alm_wr_idx = 2; alm_wr_hrs = 7; alm_wr_mins = 30; alm_wr_arm = 0;
        cyc(); alm_wr_en = 0; cur_secs = 1;
        chk("wr_old", alert_active, 1);
        ack = 1; cyc(); ack = 0;
        cur_secs = 0; cyc(); cur_secs = 1;
        chk("wr_new", alert_active, 0);

        // top of the hour
        set_t(13, 0, 0); cyc(); cur_secs = 1;
`ifdef HOURLY_CHIME_EN
        chk("t6_src", alert_src, 3); chk("t6_led1", led, 1);
        cyc();
        chk("t6_led2", led, 1); chk("t6_src2", alert_src, 3);
        cyc();
        chk("t6_end", alert_active, 0);
`else
        chk("t6_none", alert_active, 0); chk("t6_src", alert_src, 0);
`endif

        // reset in the middle of an alert clears outputs and the table
        wr(1, 8, 15, 1);
        set_t(8, 15, 0); cyc(); cur_secs = 1; cyc();
        chk("t1_pre", alert_active, 1);
        reset = 1; #1;
        chk("t1_led", led, 0); chk("t1_act", alert_active, 0);
        chk("t1_src", alert_src, 0); chk("t1_snz", snooze_pend, 0);
        cyc(); reset = 0;
        set_t(8, 15, 0); cyc(); cur_secs = 1;
        chk("t1_disarmed", alert_active, 0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
